ex_flush_ctrl: RTL and testbench
================================

EX_FLUSH_CTRL -- requirements
Module: ex_flush_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held before redirect (legal 1..15).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-004 SHALL have port wb_ex_valid, input, 1, meaning an exception is committing at writeback this cycle.
REQ-005 SHALL have port wb_is_ertn, input, 1, meaning an ERTN is committing at writeback this cycle.
REQ-006 SHALL have ports wb_ex_pc [31:0], wb_ecode [5:0] and wb_esubcode [8:0], all inputs, meaning the faulting PC and exception codes from writeback.
REQ-007 SHALL have ports csr_eentry [31:0] and csr_era [31:0], both inputs, meaning the exception entry and return address from the CSR file.
REQ-008 SHALL have port if_redirect_ready, input, 1, meaning fetch accepts the redirect this cycle.
REQ-009 SHALL have port flush, output, 1, meaning kill all pipeline stages.
REQ-010 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, [31:0]), meaning the fetch redirect request and its target.
REQ-011 SHALL have ports csr_ex_commit and csr_ertn_commit, outputs, 1 each, meaning single-cycle CSR update pulses.
REQ-012 SHALL have ports csr_ex_pc [31:0], csr_ecode [5:0] and csr_esubcode [8:0], all outputs, meaning latched exception info for the CSR file.
REQ-013 SHALL have port busy, output, 1, meaning the controller is not IDLE.
REQ-014 SHALL have ports ex_count [15:0] and ertn_count [15:0], outputs, meaning saturating event counters.

Function
REQ-015 SHALL implement FSM states IDLE, FLUSH and REDIRECT.
REQ-016 In IDLE, when wb_ex_valid=1 or wb_is_ertn=1 at edge T, SHALL enter FLUSH at T+1.
- If both are 1, the exception SHALL take priority and the ERTN SHALL be dropped.
REQ-017 At capture SHALL latch:
- kind (ex or ertn);
- wb_ex_pc, wb_ecode and wb_esubcode;
- target = csr_eentry for an exception, csr_era for an ERTN.
REQ-018 In the first FLUSH cycle SHALL pulse exactly one of csr_ex_commit or csr_ertn_commit for exactly 1 cycle; csr_ex_pc, csr_ecode and csr_esubcode SHALL hold the latched values from FLUSH entry until the next capture.
REQ-019 SHALL remain in FLUSH exactly FLUSH_CYCLES cycles using a 4-bit down-counter loaded at capture, then enter REDIRECT.
REQ-020 SHALL assert flush=1 in FLUSH and REDIRECT, and flush=0 in IDLE.
REQ-021 In REDIRECT SHALL assert redirect_valid=1, with redirect_pc equal to the latched target and held stable while valid.
REQ-022 In REDIRECT, a cycle with redirect_valid & if_redirect_ready SHALL complete the transfer and return to IDLE on the next edge; while ready=0 SHALL stay in REDIRECT indefinitely.
REQ-023 SHALL ignore wb_ex_valid and wb_is_ertn while not IDLE: no capture and no counting.
- A new event in the same cycle as IDLE re-entry SHALL be captured normally.
REQ-024 SHALL drive busy=1 exactly when the state is not IDLE.
REQ-025 SHALL increment ex_count or ertn_count by 1 per accepted event, saturating at 16'hFFFF with no wrap.
REQ-026 SHALL register all outputs or decode them purely from registered state, with no combinational path from inputs to outputs.

Reset
REQ-027 On reset=1 SHALL asynchronously force state=IDLE and all outputs and counters to 0, including mid-FLUSH or mid-REDIRECT.
REQ-028 After reset deasserts, SHALL accept an event on the first rising edge.

Verification
REQ-029 SHALL pass each of the following directed scenarios:
- Exception, FLUSH_CYCLES=2, wb_ex_pc=0x1c000010, ecode=0x0B, eentry=0x1c008000 at T, ready=1 -> flush at T+1..T+3; csr_ex_commit only at T+1; redirect_valid at T+3 with pc=0x1c008000; idle at T+4; ex_count=1.
- ERTN with era=0x1c000020 and ready held 0 for 5 cycles -> redirect_valid and pc=0x1c000020 stable for 6 cycles; csr_ertn_commit pulsed once; ertn_count=1.
- wb_ex_valid=1 and wb_is_ertn=1 simultaneously -> exception path only; ex_count=1, ertn_count=0; target=eentry.
- Second exception during FLUSH -> ignored: count unchanged, no extra commit pulse, original target kept.
- Reset asserted mid-REDIRECT -> flush, redirect_valid and busy drop to 0 without a clock edge; counters=0.
- ex_count preloaded to 0xFFFE, then 3 exceptions -> ex_count=0xFFFF and no wrap.

Source files
------------

// File: rtl/ex_flush_ctrl.sv
// Exception/ERTN flush controller: captures a writeback event, holds flush for
// FLUSH_CYCLES cycles, then redirects fetch to the exception entry or return address.
module ex_flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex_valid,
    input  logic        wb_is_ertn,
    input  logic [31:0] wb_ex_pc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        if_redirect_ready,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        csr_ex_commit,
    output logic        csr_ertn_commit,
    output logic [31:0] csr_ex_pc,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic        busy,
    output logic [15:0] ex_count,
    output logic [15:0] ertn_count
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned EVT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               capture_c;

    // Events are only accepted from IDLE; an exception wins over a simultaneous ERTN.
    assign capture_c = (state_q == IDLE) && (wb_ex_valid || wb_is_ertn);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is loaded with FLUSH_CYCLES-1 so that zero marks the last flush cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (capture_c) begin
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = REDIRECT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REDIRECT: begin
                if (if_redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status outputs registered from the next state so they track state_q exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush           <= 1'b0;
            busy            <= 1'b0;
            redirect_valid  <= 1'b0;
            csr_ex_commit   <= 1'b0;
            csr_ertn_commit <= 1'b0;
        end else begin
            flush           <= (state_d != IDLE);
            busy            <= (state_d != IDLE);
            redirect_valid  <= (state_d == REDIRECT);
            csr_ex_commit   <= capture_c && wb_ex_valid;
            csr_ertn_commit <= capture_c && !wb_ex_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_pc  <= '0;
            csr_ex_pc    <= '0;
            csr_ecode    <= '0;
            csr_esubcode <= '0;
        end else if (capture_c) begin
            redirect_pc  <= wb_ex_valid ? csr_eentry : csr_era;
            csr_ex_pc    <= wb_ex_pc;
            csr_ecode    <= wb_ecode;
            csr_esubcode <= wb_esubcode;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_count   <= '0;
            ertn_count <= '0;
        end else if (capture_c) begin
            if (wb_ex_valid) begin
                if (ex_count != '1) begin
                    ex_count <= ex_count + EVT_W'(1);
                end
            end else if (ertn_count != '1) begin
                ertn_count <= ertn_count + EVT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_flush_ctrl.sv
// Bench for ex_flush_ctrl: directed vector table, hand-written corner sequences and
// random stimulus checked against a cycle-age model of the flush/redirect protocol.
module tb_ex_flush_ctrl;

    localparam int unsigned FC = 2;

    logic        clk;
    logic        reset;
    logic        i_ex;
    logic        i_ertn;
    logic [31:0] i_pc;
    logic [5:0]  i_ecode;
    logic [8:0]  i_esub;
    logic [31:0] i_eentry;
    logic [31:0] i_era;
    logic        i_ready;
    logic        o_flush;
    logic        o_rv;
    logic [31:0] o_rpc;
    logic        o_exc;
    logic        o_ertnc;
    logic [31:0] o_cpc;
    logic [5:0]  o_ecode;
    logic [8:0]  o_esub;
    logic        o_busy;
    logic [15:0] o_exn;
    logic [15:0] o_ertnn;

    ex_flush_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_ex_valid      (i_ex),
        .wb_is_ertn       (i_ertn),
        .wb_ex_pc         (i_pc),
        .wb_ecode         (i_ecode),
        .wb_esubcode      (i_esub),
        .csr_eentry       (i_eentry),
        .csr_era          (i_era),
        .if_redirect_ready(i_ready),
        .flush            (o_flush),
        .redirect_valid   (o_rv),
        .redirect_pc      (o_rpc),
        .csr_ex_commit    (o_exc),
        .csr_ertn_commit  (o_ertnc),
        .csr_ex_pc        (o_cpc),
        .csr_ecode        (o_ecode),
        .csr_esubcode     (o_esub),
        .busy             (o_busy),
        .ex_count         (o_exn),
        .ertn_count       (o_ertnn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: an event is "age" cycles old; ages 1..FC are flush, later is redirect.
    bit          m_active;
    int          m_age;
    bit          m_kind_ex;
    logic [31:0] m_pc;
    logic [5:0]  m_ecode;
    logic [8:0]  m_esub;
    logic [31:0] m_target;
    logic [15:0] m_exn;
    logic [15:0] m_ertnn;

    typedef struct {
        logic        ex;
        logic        ertn;
        logic [31:0] pc;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] eentry;
        logic [31:0] era;
        int          wait_cycles;
        logic [31:0] exp_target;
        logic        exp_is_ex;
        int          exp_busy;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_age = 0; m_kind_ex = 0;
        m_pc = '0; m_ecode = '0; m_esub = '0; m_target = '0;
        m_exn = '0; m_ertnn = '0;
    endtask

    task automatic model_edge();
        if (m_active) begin
            if (m_age > int'(FC)) begin
                if (i_ready) m_active = 0;
            end else begin
                m_age++;
            end
        end else if (i_ex || i_ertn) begin
            m_active  = 1;
            m_age     = 1;
            m_kind_ex = i_ex;
            m_pc      = i_pc;
            m_ecode   = i_ecode;
            m_esub    = i_esub;
            m_target  = i_ex ? i_eentry : i_era;
            if (i_ex) begin
                if (m_exn != 16'hFFFF) m_exn = m_exn + 16'd1;
            end else if (m_ertnn != 16'hFFFF) begin
                m_ertnn = m_ertnn + 16'd1;
            end
        end
    endtask

    task automatic check_all();
        bit redir;
        redir = m_active && (m_age > int'(FC));
        chk("flush",           32'(o_flush),  32'(m_active));
        chk("busy",            32'(o_busy),   32'(m_active));
        chk("redirect_valid",  32'(o_rv),     32'(redir));
        chk("redirect_pc",     o_rpc,         m_target);
        chk("csr_ex_commit",   32'(o_exc),    32'(m_active && m_age == 1 && m_kind_ex));
        chk("csr_ertn_commit", 32'(o_ertnc),  32'(m_active && m_age == 1 && !m_kind_ex));
        chk("csr_ex_pc",       o_cpc,         m_pc);
        chk("csr_ecode",       32'(o_ecode),  32'(m_ecode));
        chk("csr_esubcode",    32'(o_esub),   32'(m_esub));
        chk("ex_count",        32'(o_exn),    32'(m_exn));
        chk("ertn_count",      32'(o_ertnn),  32'(m_ertnn));
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_inputs();
        i_ex = 0; i_ertn = 0; i_pc = '0; i_ecode = '0; i_esub = '0;
        i_eentry = '0; i_era = '0; i_ready = 0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [15:0] exn0, ertnn0;
        int busy_n, exp_n, ertnp_n, rv_n, guard;
        exn0 = m_exn; ertnn0 = m_ertnn;
        busy_n = 0; exp_n = 0; ertnp_n = 0; rv_n = 0; guard = 0;
        i_ex = v.ex; i_ertn = v.ertn; i_pc = v.pc; i_ecode = v.ecode; i_esub = v.esub;
        i_eentry = v.eentry; i_era = v.era; i_ready = 1'b1;
        step();
        i_ex = 0; i_ertn = 0;
        while (o_busy && guard < 64) begin
            busy_n++;
            if (o_exc) exp_n++;
            if (o_ertnc) ertnp_n++;
            if (o_rv) begin
                rv_n++;
                chk({tag, "_target"}, o_rpc, v.exp_target);
            end
            i_ready = o_rv && (rv_n > v.wait_cycles);
            step();
            guard++;
        end
        chk({tag, "_timeout"}, 32'(guard >= 64), 32'd0);
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
        chk({tag, "_rv_cycles"}, 32'(rv_n), 32'(v.wait_cycles + 1));
        chk({tag, "_ex_pulses"}, 32'(exp_n), 32'(v.exp_is_ex));
        chk({tag, "_ertn_pulses"}, 32'(ertnp_n), 32'(!v.exp_is_ex));
        chk({tag, "_ex_delta"}, 32'(o_exn - exn0), 32'(v.exp_is_ex));
        chk({tag, "_ertn_delta"}, 32'(o_ertnn - ertnn0), 32'(!v.exp_is_ex));
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h1c000010, 6'h0B, 9'h000, 32'h1c008000, 32'h1c000020,
                    0, 32'h1c008000, 1'b1, FC + 1};
        vecs[1] = '{1'b0, 1'b1, 32'h1c000044, 6'h00, 9'h000, 32'h1c008000, 32'h1c000020,
                    5, 32'h1c000020, 1'b0, FC + 6};
        vecs[2] = '{1'b1, 1'b1, 32'h1c000080, 6'h08, 9'h001, 32'h1c00a000, 32'h1c000090,
                    0, 32'h1c00a000, 1'b1, FC + 1};
        vecs[3] = '{1'b1, 1'b0, 32'hdeadbee0, 6'h3F, 9'h1FF, 32'h80001000, 32'h1234_5678,
                    2, 32'h80001000, 1'b1, FC + 3};

        clear_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all();
        reset = 1'b0;

        for (int k = 0; k < 4; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Second exception during FLUSH is ignored.
        begin
            logic [15:0] n0;
            n0 = m_exn;
            i_ex = 1; i_pc = 32'h00000100; i_ecode = 6'h01; i_eentry = 32'h00002000; i_ready = 1;
            step();
            i_pc = 32'h00000200; i_ecode = 6'h02; i_eentry = 32'h00003000;
            step();
            chk("flush2_count", 32'(o_exn), 32'(n0 + 16'd1));
            chk("flush2_commit", 32'(o_exc), 32'd0);
            i_ex = 0;
            for (int g = 0; g < 16 && o_busy; g++) begin
                if (o_rv) chk("flush2_target", o_rpc, 32'h00002000);
                step();
            end
            chk("flush2_idle", 32'(o_busy), 32'd0);
        end

        // Reset mid-REDIRECT drops outputs without a clock edge; event accepted right after.
        begin
            i_ertn = 1; i_era = 32'h0000abc0; i_ready = 0;
            step();
            i_ertn = 0;
            for (int g = 0; g < int'(FC); g++) step();
            chk("pre_reset_rv", 32'(o_rv), 32'd1);
            #2 reset = 1'b1;
            #1;
            chk("rst_flush", 32'(o_flush), 32'd0);
            chk("rst_rv", 32'(o_rv), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_exn", 32'(o_exn), 32'd0);
            chk("rst_ertnn", 32'(o_ertnn), 32'd0);
            model_reset();
            @(negedge clk);
            reset = 1'b0;
            i_ex = 1; i_pc = 32'h00000400; i_eentry = 32'h00005000; i_ready = 1;
            step();
            chk("post_reset_accept", 32'(o_flush), 32'd1);
            i_ex = 0;
            for (int g = 0; g < 16 && o_busy; g++) step();
        end

        // Saturation from a preloaded count.
        begin
            @(negedge clk);
            force dut.ex_count = 16'hFFFE;
            #1 release dut.ex_count;
            m_exn = 16'hFFFE;
            for (int e = 0; e < 3; e++) begin
                i_ex = 1; i_eentry = 32'h00006000; i_ready = 1;
                step();
                i_ex = 0;
                for (int g = 0; g < 16 && o_busy; g++) step();
            end
            chk("sat_ex_count", 32'(o_exn), 32'h0000FFFF);
        end

        // Random traffic against the model.
        for (int r = 0; r < 1500; r++) begin
            i_ex     = ($urandom_range(3) == 0);
            i_ertn   = ($urandom_range(3) == 0);
            i_pc     = $urandom;
            i_ecode  = 6'($urandom);
            i_esub   = 9'($urandom);
            i_eentry = $urandom;
            i_era    = $urandom;
            i_ready  = 1'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
